// File: rtl/neuron_requant_pack_pkg.sv
// Shared types and constants for the CIM neuron requantize/pack stage.
package neuron_requant_pack_pkg;

  localparam int SUM_W     = 12;
  localparam int ACT_W     = 9;
  localparam int NUM_LANES = 8;
  localparam int IDX_W     = $clog2(NUM_LANES);
  localparam int VEC_W     = ACT_W * NUM_LANES;

  localparam int ACT_MAX = 255;
  localparam int ACT_MIN = -256;

  // COLLECT: filling the collection buffer; FULL: buffer holds a finished
  // vector waiting for the output register to free up.
  typedef enum logic {
    COLLECT = 1'b0,
    FULL    = 1'b1
  } state_e;

  typedef logic signed [ACT_W-1:0] act_t;
  typedef logic [VEC_W-1:0]        vec_t;

endpackage

// File: rtl/neuron_requant_pack_if.sv
// Sum-in / vector-out handshake bundle for neuron_requant_pack.
interface neuron_requant_pack_if;
  import neuron_requant_pack_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [SUM_W-1:0] in_sum;
  logic             out_valid;
  logic             out_ready;
  vec_t             out_act;
  logic             out_sat;

  // Producer of sums and consumer of vectors.
  modport master (
    output in_valid, in_sum, out_ready,
    input  in_ready, out_valid, out_act, out_sat
  );

  // The requant/pack block itself.
  modport slave (
    input  in_valid, in_sum, out_ready,
    output in_ready, out_valid, out_act, out_sat
  );

endinterface

// File: rtl/neuron_requant_pack_requant_lane.sv
// Combinational requantizer: optional ReLU, rounding arithmetic shift, saturation.
module neuron_requant_pack_requant_lane
  import neuron_requant_pack_pkg::*;
#(
  parameter int SHIFT = 3,
  parameter bit RELU  = 1'b1
) (
  input  logic signed [SUM_W-1:0] in_sum,
  output act_t                    act,
  output logic                    sat
);

  // Half-LSB rounding constant; zero when no shift is applied.
  localparam logic signed [SUM_W:0] RND =
    (SHIFT > 0) ? (13'sd1 <<< ((SHIFT > 0) ? SHIFT - 1 : 0)) : 13'sd0;
  localparam logic signed [SUM_W:0] HI  = 13'(ACT_MAX);
  localparam logic signed [SUM_W:0] LO  = RELU ? 13'(0) : 13'(ACT_MIN);

  logic signed [SUM_W:0] sum_ext;
  logic signed [SUM_W:0] shifted;

  // Widen by one bit so the rounding add cannot overflow, then clamp.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    sum_ext = {in_sum[SUM_W-1], in_sum};
    shifted = '0;
    act     = '0;
    sat     = 1'b0;
    if (RELU && in_sum[SUM_W-1]) begin
      shifted = '0;
    end else begin
      shifted = (sum_ext + RND) >>> SHIFT;
    end
    if (shifted > HI) begin
      act = HI[ACT_W-1:0];
      sat = 1'b1;
    end else if (shifted < LO) begin
      act = LO[ACT_W-1:0];
      sat = 1'b1;
    end else begin
      act = shifted[ACT_W-1:0];
    end
  end

endmodule

// File: rtl/neuron_requant_pack.sv
// Requantizes neuron sums and packs eight lanes into a double-buffered activation vector.
module neuron_requant_pack
  import neuron_requant_pack_pkg::*;
#(
  parameter int SHIFT = 3,
  parameter bit RELU  = 1'b1
) (
  input logic                  clk,
  input logic                  rst_n,
  neuron_requant_pack_if.slave bus
);

  state_e           state_q, state_d;
  logic             alive_q;
  logic [IDX_W-1:0] idx_q;
  act_t             lane_q [NUM_LANES];
  logic             buf_sat_q;
  vec_t             out_act_q;
  logic             out_valid_q;
  logic             out_sat_q;

  act_t             lane_act;
  logic             lane_sat;
  vec_t             buf_vec;
  logic             in_ready_c;
  logic             accept;
  logic             last;
  logic             out_xfer;
  logic             out_free;
  logic             load_live;
  logic             load_buf;

  neuron_requant_pack_requant_lane #(
    .SHIFT (SHIFT),
    .RELU  (RELU)
  ) u_lane (
    .in_sum ($signed(bus.in_sum)),
    .act    (lane_act),
    .sat    (lane_sat)
  );

  // State register; alive_q keeps in_ready low until the first edge after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: clocked blocks use non-blocking assignments so all registers see pre-edge values.
    if (!rst_n) begin
      state_q <= COLLECT;
      alive_q <= 1'b0;
    end else begin
      state_q <= state_d;
      alive_q <= 1'b1;
    end
  end

  // Next state: park in FULL when a vector completes but the output is occupied.
  always_comb begin
    state_d = state_q;
    case (state_q)
      COLLECT: if (last && !out_free) state_d = FULL;
      FULL:    if (out_xfer)          state_d = COLLECT;
      default: state_d = COLLECT;
    endcase
  end

  // FSM outputs and handshake qualifiers; in_ready comes from registers only.
  always_comb begin
    in_ready_c = alive_q && (state_q == COLLECT);
    accept     = bus.in_valid && in_ready_c;
    last       = accept && (idx_q == IDX_W'(NUM_LANES - 1));
    out_xfer   = out_valid_q && bus.out_ready;
    out_free   = !out_valid_q || out_xfer;
    load_live  = (state_q == COLLECT) && last && out_free;
    load_buf   = (state_q == FULL) && out_xfer;
  end

  // Flatten the collection lanes into vector layout (lane 0 in the LSBs).
  always_comb begin
    buf_vec = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      buf_vec[k*ACT_W +: ACT_W] = lane_q[k];
    end
  end

  // Collection lanes; stale contents are harmless because idx restarts at 0.
  always_ff @(posedge clk) begin
    // NOTE: lane storage is deliberately not reset; every lane is rewritten before it is read.
    if (accept) lane_q[idx_q] <= lane_act;
  end

  // Write index and OR-accumulated saturation flag for the vector being built.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q     <= '0;
      buf_sat_q <= 1'b0;
    end else begin
      if (accept) idx_q <= last ? '0 : idx_q + 1'b1;
      if (load_live || load_buf) begin
        buf_sat_q <= 1'b0;
      end else if (accept) begin
        buf_sat_q <= buf_sat_q | lane_sat;
      end
    end
  end

  // Output register: live load bypasses the 8th lane, buffered load drains FULL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_act_q   <= '0;
      out_sat_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (load_live) begin
      out_act_q   <= {lane_act, buf_vec[VEC_W-ACT_W-1:0]};
      out_sat_q   <= buf_sat_q | lane_sat;
      out_valid_q <= 1'b1;
    end else if (load_buf) begin
      out_act_q   <= buf_vec;
      out_sat_q   <= buf_sat_q;
      out_valid_q <= 1'b1;
    end else if (out_xfer) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.out_act   = out_act_q;
  assign bus.out_sat   = out_sat_q;

endmodule

// File: tb/tb_neuron_requant_pack.sv
// Self-checking bench: three configurations share one stimulus stream and one vector-level model.
module tb_neuron_requant_pack;
  import neuron_requant_pack_pkg::*;

  localparam int NDUT = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [11:0] in_sum = '0;
  logic        out_ready = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  neuron_requant_pack_if if0 ();
  neuron_requant_pack_if if1 ();
  neuron_requant_pack_if if2 ();

  assign if0.in_valid = in_valid;  assign if0.in_sum = in_sum;  assign if0.out_ready = out_ready;
  assign if1.in_valid = in_valid;  assign if1.in_sum = in_sum;  assign if1.out_ready = out_ready;
  assign if2.in_valid = in_valid;  assign if2.in_sum = in_sum;  assign if2.out_ready = out_ready;

  neuron_requant_pack #(.SHIFT(3), .RELU(1'b1)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  neuron_requant_pack #(.SHIFT(3), .RELU(1'b0)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  neuron_requant_pack #(.SHIFT(0), .RELU(1'b0)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

  logic v_w [NDUT];
  logic r_w [NDUT];
  logic s_w [NDUT];
  vec_t act_w [NDUT];

  assign v_w[0] = if0.out_valid;  assign r_w[0] = if0.in_ready;
  assign s_w[0] = if0.out_sat;    assign act_w[0] = if0.out_act;
  assign v_w[1] = if1.out_valid;  assign r_w[1] = if1.in_ready;
  assign s_w[1] = if1.out_sat;    assign act_w[1] = if1.out_act;
  assign v_w[2] = if2.out_valid;  assign r_w[2] = if2.in_ready;
  assign s_w[2] = if2.out_sat;    assign act_w[2] = if2.out_act;

  function automatic int cfg_shift(input int i);
    return (i == 2) ? 0 : 3;
  endfunction

  function automatic bit cfg_relu(input int i);
    return (i == 0);
  endfunction

  task automatic check(input string name, input logic [95:0] got, input logic [95:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  // Reference requantizer: exact floor division, no bit tricks.
  function automatic int rq(input int s, input int shift, input bit relu, output bit sat);
    int r, den, num, lo;
    if (relu && s < 0) r = 0;
    else if (shift == 0) r = s;
    else begin
      den = 1 << shift;
      num = s + den / 2;
      r = num / den;
      if ((num % den) != 0 && num < 0) r = r - 1;
    end
    lo  = relu ? 0 : -256;
    sat = 1'b0;
    if (r > 255) begin r = 255; sat = 1'b1; end
    else if (r < lo) begin r = lo; sat = 1'b1; end
    return r;
  endfunction

  // Expected {sat, vector} for a group of eight 12-bit sums (first sum in the low bits).
  function automatic logic [72:0] model_vec(input logic [95:0] g, input int shift, input bit relu);
    vec_t v = '0;
    bit any = 1'b0;
    bit s;
    int a;
    logic [11:0] raw;
    for (int k = 0; k < 8; k++) begin
      raw = g[k*12 +: 12];
      a = rq(int'($signed(raw)), shift, relu, s);
      any = any | s;
      v[k*9 +: 9] = a[8:0];
    end
    return {any, v};
  endfunction

  function automatic vec_t pack_lanes(input int l[8]);
    vec_t v = '0;
    int t;
    for (int k = 0; k < 8; k++) begin
      t = l[k];
      v[k*9 +: 9] = t[8:0];
    end
    return v;
  endfunction

  // Model state: sums of the vector being gathered, and finished vectors not yet taken.
  logic [11:0] part_q [$];
  logic [95:0] grp_q [$];
  logic        hold_prev = 1'b0;
  vec_t        prev_act [NDUT];
  logic        prev_sat [NDUT];

  // Compare process: sampled on the falling edge, between input updates and the active edge.
  always @(negedge clk) begin
    logic [95:0] g;
    if (!rst_n) begin
      for (int i = 0; i < NDUT; i++) begin
        check($sformatf("rst_valid%0d", i), v_w[i], 0);
        check($sformatf("rst_ready%0d", i), r_w[i], 0);
      end
      part_q.delete();
      grp_q.delete();
      hold_prev = 1'b0;
    end else begin
      for (int i = 0; i < NDUT; i++) begin
        check($sformatf("out_valid%0d", i), v_w[i], grp_q.size() > 0);
        check($sformatf("in_ready%0d", i), r_w[i], grp_q.size() < 2);
        if (hold_prev) begin
          check($sformatf("hold_act%0d", i), act_w[i], prev_act[i]);
          check($sformatf("hold_sat%0d", i), s_w[i], prev_sat[i]);
        end
      end
      if (v_w[0] && out_ready) begin
        check("xfer_pending", grp_q.size() > 0, 1);
        if (grp_q.size() > 0) begin
          for (int i = 0; i < NDUT; i++) begin
            check($sformatf("vector%0d", i), {s_w[i], act_w[i]},
                  model_vec(grp_q[0], cfg_shift(i), cfg_relu(i)));
          end
          void'(grp_q.pop_front());
        end
      end
      if (in_valid && r_w[0]) begin
        part_q.push_back(in_sum);
        if (part_q.size() == 8) begin
          g = '0;
          for (int k = 0; k < 8; k++) g[k*12 +: 12] = part_q[k];
          grp_q.push_back(g);
          part_q.delete();
        end
      end
      hold_prev = v_w[0] && !out_ready;
      for (int i = 0; i < NDUT; i++) begin
        prev_act[i] = act_w[i];
        prev_sat[i] = s_w[i];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one sum and hold it until accepted (bounded wait).
  task automatic send(input logic [11:0] s);
    int n = 0;
    in_valid = 1'b1;
    in_sum   = s;
    @(negedge clk);
    while (!r_w[0] && n < 50) begin
      n++;
      @(negedge clk);
    end
    check("send_accept", r_w[0], 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst_n     = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_act", act_w[0], 0);
    check("rst_sat", s_w[0], 0);
    #2 rst_n = 1'b1;
    tick();
    check("ready_after_rst", r_w[0], 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int  lanes [8];
    int  sums [8];
    bit  s;
    int  r;

    do_reset();

    // Pin the reference requantizer to hand-computed values.
    r = rq(100, 3, 1'b1, s);    check("model_100", {s, 32'(r)}, {1'b0, 32'd13});
    r = rq(2047, 3, 1'b1, s);   check("model_2047", {s, 32'(r)}, {1'b1, 32'd255});
    r = rq(-2048, 3, 1'b0, s);  check("model_m2048", {s, 32'(r)}, {1'b0, 32'(-256)});
    r = rq(-5, 3, 1'b0, s);     check("model_m5", {s, 32'(r)}, {1'b0, 32'(-1)});

    // ReLU, shift 3, back-to-back with a ready consumer.
    out_ready = 1'b1;
    sums = '{100, -50, 2047, 7, 3, 4, 0, -1};
    for (int k = 0; k < 8; k++) send(12'(sums[k]));
    lanes = '{13, 0, 255, 1, 0, 1, 0, 0};
    check("t1_valid", v_w[0], 1);
    check("t1_act", act_w[0], pack_lanes(lanes));
    check("t1_sat", s_w[0], 1);
    tick();
    check("t1_valid_pulse", v_w[0], 0);

    // Signed pass-through, shift 3, with a lane saturating from 256.
    sums = '{-2048, -2047, 2039, -4, -5, 12, 0, 2047};
    for (int k = 0; k < 8; k++) send(12'(sums[k]));
    lanes = '{-256, -256, 255, 0, -1, 2, 0, 255};
    check("t2_act", act_w[1], pack_lanes(lanes));
    check("t2_sat", s_w[1], 1);

    // Shift 0: saturation in both directions, then an in-range vector.
    sums = '{300, -300, 100, 0, 0, 0, 0, 0};
    for (int k = 0; k < 8; k++) send(12'(sums[k]));
    lanes = '{255, -256, 100, 0, 0, 0, 0, 0};
    check("t3_act", act_w[2], pack_lanes(lanes));
    check("t3_sat", s_w[2], 1);
    for (int k = 0; k < 8; k++) send(12'd100);
    lanes = '{100, 100, 100, 100, 100, 100, 100, 100};
    check("t3_act_nosat", act_w[2], pack_lanes(lanes));
    check("t3_nosat", s_w[2], 0);
    tick();

    // Backpressure: two vectors queue up, the second in the collection buffer.
    out_ready = 1'b0;
    for (int k = 0; k < 8; k++) send(12'd8);
    lanes = '{1, 1, 1, 1, 1, 1, 1, 1};
    check("t4_first_valid", v_w[0], 1);
    check("t4_first_act", act_w[0], pack_lanes(lanes));
    for (int k = 0; k < 8; k++) send(12'd16);
    check("t4_ready_drop", r_w[0], 0);
    repeat (3) tick();
    check("t4_held_act", act_w[0], pack_lanes(lanes));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    lanes = '{2, 2, 2, 2, 2, 2, 2, 2};
    check("t4_second_valid", v_w[0], 1);
    check("t4_second_act", act_w[0], pack_lanes(lanes));
    check("t4_ready_back", r_w[0], 1);

    // Simultaneous 8th accept and output transfer: no bubble.
    for (int k = 0; k < 7; k++) send(12'd24);
    check("t5_valid_before", v_w[0], 1);
    out_ready = 1'b1;
    send(12'd24);
    lanes = '{3, 3, 3, 3, 3, 3, 3, 3};
    check("t5_valid_after", v_w[0], 1);
    check("t5_act", act_w[0], pack_lanes(lanes));
    tick();
    check("t5_drained", v_w[0], 0);

    // Asynchronous reset mid-vector with a vector held at the output.
    out_ready = 1'b0;
    for (int k = 0; k < 13; k++) send(12'($urandom));
    #3 rst_n = 1'b0;
    #1;
    check("t6_valid_async", v_w[0], 0);
    check("t6_ready_async", r_w[0], 0);
    check("t6_act_async", act_w[0], 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    tick();
    out_ready = 1'b1;
    send(12'd77);
    for (int k = 0; k < 7; k++) send(12'($urandom));
    check("t6_valid", v_w[2], 1);
    check("t6_lane0", act_w[2][8:0], 9'd77);

    // Randomized traffic with varying consumer stall density.
    for (int blk = 0; blk < 6; blk++) begin
      for (int c = 0; c < 500; c++) begin
        in_valid  = ($urandom_range(0, 3) != 0);
        in_sum    = ($urandom_range(0, 1) != 0) ? 12'($urandom) : 12'($signed($urandom_range(0, 80)) - 40);
        out_ready = ($urandom_range(0, 5) < (blk + 1));
        tick();
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (20) tick();
    check("final_drain", grp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
